// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the FFT control sequencer
//
// Purpose : transform-size constants, the sequencer state encoding and the
//           write-back tag record that travels alongside each butterfly.
// Ports   : none (package).
package fft_pkg;

  localparam int LOG2N   = 10;
  localparam int N_PAIRS = 1 << (LOG2N - 1);
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int PAIR_W  = LOG2N - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fft_seq_state_t;

  typedef struct packed {
    logic               valid;
    logic [STAGE_W-1:0] stage;
    logic [PAIR_W-1:0]  pair;
  } fft_wb_tag_t;

  function automatic fft_wb_tag_t make_tag(input logic               valid,
                                           input logic [STAGE_W-1:0] stage,
                                           input logic [PAIR_W-1:0]  pair);
    fft_wb_tag_t t;
    t.valid = valid;
    t.stage = stage;
    t.pair  = pair;
    return t;
  endfunction

endpackage

// File: rtl/fft_tag_delay.sv
// rtl/fft_tag_delay.sv - fixed-depth shift register for write-back tags
//
// Purpose : delays a write-back tag by DEPTH clock cycles so that the write
//           side sees the stage/pair whose butterfly result is arriving.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset, clears every entry
//           shift_in  - tag entering the line this cycle
//           shift_out - tag that entered DEPTH cycles ago
module fft_tag_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  fft_wb_tag_t shift_in,
  output fft_wb_tag_t shift_out
);

  fft_wb_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign shift_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - issue sequencer for the in-place radix-2 FFT core
//
// Purpose : walks pair 0..N/2-1 of every stage once per transform, drives the
//           address generator's enable/stage/pair, inserts a drain gap of
//           PIPE_LAT cycles between stages and delays a {valid,stage,pair}
//           write-back tag by PIPE_LAT cycles.
// Config  : FFT_SEQ_CYCLE_COUNT_EN adds the 16-bit busy-cycle counter o_cycles.
// Ports   : i_clk       - clock, rising edge
//           i_rst_n     - asynchronous active-low reset
//           i_start     - start one transform (only honoured in IDLE)
//           i_hold      - pause issue while running
//           o_busy      - transform in progress (RUN, DRAIN, DONE)
//           o_done      - one-cycle pulse after the last write-back
//           o_en        - read-issue enable
//           o_stage     - issue stage
//           o_pair      - issue pair
//           o_wb_valid  - write-back tag valid
//           o_wb_stage  - write-back stage
//           o_wb_pair   - write-back pair
//           o_cycles    - busy cycles of the last/current transform (optional)
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N    = 10,
  parameter int PIPE_LAT = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_en,
  output logic [STAGE_W-1:0] o_stage,
  output logic [PAIR_W-1:0]  o_pair,
  output logic               o_wb_valid,
  output logic [STAGE_W-1:0] o_wb_stage,
  output logic [PAIR_W-1:0]  o_wb_pair
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]        o_cycles
`endif
);

  localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'((1 << (LOG2N - 1)) - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
  // PIPE_LAT is at most 15, so a 4-bit drain count always reaches its end.
  localparam logic [3:0]         DRAIN_LAST = 4'(PIPE_LAT - 1);

  fft_seq_state_t     state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [PAIR_W-1:0]  pair_q,  pair_d;
  logic               en_q,    en_d;
  logic [3:0]         drain_q, drain_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      en_q    <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
      en_q    <= en_d;
      drain_q <= drain_d;
    end
  end

  // pair_q always names the most recently issued pair. A held cycle keeps it
  // and drops en; the next unheld cycle moves on to the following pair, so
  // every pair is issued exactly once regardless of where the hold lands.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    en_d    = 1'b0;
    drain_d = drain_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          stage_d = '0;
          pair_d  = '0;
          en_d    = 1'b1;
        end
      end

      RUN: begin
        if (!i_hold) begin
          if (pair_q == LAST_PAIR) begin
            state_d = DRAIN;
            pair_d  = '0;
            drain_d = '0;
          end else begin
            pair_d = pair_q + 1'b1;
            en_d   = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q < LAST_STAGE) begin
            // The first read of the next stage goes out immediately, so
            // it lands right after the final write-back of this stage.
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            en_d    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        stage_d = '0;
        pair_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_en    = en_q;
  assign o_stage = stage_q;
  assign o_pair  = pair_q;

  fft_wb_tag_t tag_in;
  fft_wb_tag_t tag_out;

  assign tag_in = make_tag(en_q, stage_q, pair_q);

  fft_tag_delay #(
    .DEPTH(PIPE_LAT)
  ) u_tag_delay (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_in (tag_in),
    .shift_out(tag_out)
  );

  assign o_wb_valid = tag_out.valid;
  assign o_wb_stage = tag_out.stage;
  assign o_wb_pair  = tag_out.pair;

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  // Counts every cycle spent outside IDLE, so after DONE it reads the full
  // start-to-done duration and then holds until the next accepted start.
  logic [15:0] cycles_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycles_q <= '0;
    end else if (state_q == IDLE) begin
      if (i_start) begin
        cycles_q <= '0;
      end
    end else if (cycles_q != 16'hFFFF) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - self-checking bench for fft_sequencer
module tb_fft_sequencer;

  localparam int PL       = 3;
  localparam int STAGES   = 10;
  localparam int PAIRS    = 512;
  localparam int TOTAL    = STAGES * PAIRS;
  localparam int XFER_CYC = STAGES * (PAIRS + PL) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_clean = 1'b0;
  logic       hold = 1'b0;
  logic       busy, done, en, wb_valid;
  logic [3:0] stage, wb_stage;
  logic [8:0] pair, wb_pair;

  always #5 clk = ~clk;

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycles;
  logic        busy1, done1, en1, wbv1;
  logic [3:0]  st1, wbs1;
  logic [8:0]  pr1, wbp1;
  logic [15:0] cycles1;
`endif

  fft_sequencer #(.LOG2N(STAGES), .PIPE_LAT(PL)) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_hold    (hold),
    .o_busy    (busy),
    .o_done    (done),
    .o_en      (en),
    .o_stage   (stage),
    .o_pair    (pair),
    .o_wb_valid(wb_valid),
    .o_wb_stage(wb_stage),
    .o_wb_pair (wb_pair)
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    ,
    .o_cycles  (cycles)
`endif
  );

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  fft_sequencer #(.LOG2N(STAGES), .PIPE_LAT(1)) u_dut_pl1 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start_clean),
    .i_hold    (1'b0),
    .o_busy    (busy1),
    .o_done    (done1),
    .o_en      (en1),
    .o_stage   (st1),
    .o_pair    (pr1),
    .o_wb_valid(wbv1),
    .o_wb_stage(wbs1),
    .o_wb_pair (wbp1),
    .o_cycles  (cycles1)
  );
  logic pl1_after_done = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the transform is a flat list of TOTAL issues, index
  // idx = stage*PAIRS + pair. Unheld RUN cycles advance idx, the last pair
  // of a stage opens a PL-cycle gap, and the write-back is the displayed
  // tag history delayed by PL cycles.
  bit          m_busy, m_done, m_en;
  int          m_idx, m_gap;
  int          m_held = 0;
  logic [13:0] hist[$];
  logic [13:0] m_wb;

  function automatic logic [3:0] exp_stage();
    return m_busy ? 4'(m_idx / PAIRS) : 4'd0;
  endfunction

  function automatic logic [8:0] exp_pair();
    return (m_busy && !m_done && m_gap == 0) ? 9'(m_idx % PAIRS) : 9'd0;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_en = 0; m_idx = 0; m_gap = 0;
    hist.delete();
    for (int i = 0; i < PL - 1; i++) hist.push_back(14'd0);
    m_wb = '0;
  endfunction

  function automatic void model_edge();
    logic [13:0] cur;
    cur = {m_en, exp_stage(), exp_pair()};
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(cur);
    m_wb = hist.pop_front();
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_idx = 0; m_en = 1; m_gap = 0; m_done = 0;
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0; m_en = 0; m_idx = 0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (m_idx == TOTAL - 1) begin
          m_done = 1;
        end else begin
          m_idx++;
          m_en = 1;
        end
      end
    end else if (hold) begin
      m_en = 0;
      m_held++;
    end else if (m_idx % PAIRS == PAIRS - 1) begin
      m_gap = PL;
      m_en = 0;
    end else begin
      m_idx++;
      m_en = 1;
    end
  endfunction

  int          last_en_cyc = 0;
  logic [3:0]  last_en_stage = 4'd0;
  int          held_at_en = 0;
  logic [13:0] prev_wb = '0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model", {busy, done, en, stage, pair, wb_valid, wb_stage, wb_pair},
          {m_busy, m_done, m_en, exp_stage(), exp_pair(), m_wb});
    if (en === 1'b1) begin
      if (rst_n && stage != last_en_stage && stage != 4'd0) begin
        check("stage_gap", 64'(cyc - last_en_cyc - 1), 64'(PL + (m_held - held_at_en)));
        if (m_held == held_at_en)
          check("boundary_wb", prev_wb, {1'b1, 4'(stage - 4'd1), 9'd511});
      end
      last_en_cyc = cyc;
      last_en_stage = stage;
      held_at_en = m_held;
    end
    prev_wb = {wb_valid, wb_stage, wb_pair};
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    if (pl1_after_done) check("cycles_pl1", cycles1, 64'd5131);
    pl1_after_done = (done1 === 1'b1);
`endif
  endtask

  bit rand_hold = 0;
  bit rand_start = 0;

  task automatic do_start(output int t0);
    start = 1; start_clean = 1;
    step();
    start = 0; start_clean = 0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      hold  = rand_hold  ? ($urandom_range(0, 15) == 0) : 1'b0;
      start = rand_start ? ($urandom_range(0, 63) == 0) : 1'b0;
      step();
      n++;
    end
    hold = 0; start = 0;
    check("done_seen", done, 1);
    dcyc = cyc;
  endtask

  task automatic after_done(input int expect_cycles);
    step();
    check("idle_after_done", {busy, done, stage, pair}, 0);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    check("cycles_main", cycles, 64'(expect_cycles));
`else
    if (expect_cycles < 0) $display("unexpected cycle budget %0d", expect_cycles);
`endif
  endtask

  typedef struct packed {
    logic       start;
    logic       hold;
    logic       busy;
    logic       en;
    logic [8:0] pair;
    logic       wbv;
    logic [8:0] wbp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int t0, dcyc, h0, n;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 9'd0, 1'b0, 9'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'd1, 1'b0, 9'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 1'b0, 9'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 1'b1, 9'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'd2, 1'b1, 9'd1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 9'd3, 1'b0, 9'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'd4, 1'b0, 9'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'd5, 1'b1, 9'd2};

    model_reset();
    repeat (3) step();
    check("reset_state", {busy, done, en, stage, pair, wb_valid, wb_stage, wb_pair}, 0);
    rst_n = 1;

    // Transform 1: table vectors open it, then it runs to completion.
    t0 = 0;
    h0 = m_held;
    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start;
      start_clean = (i == 1);
      hold = vecs[i].hold;
      step();
      start = 0; start_clean = 0; hold = 0;
      check($sformatf("vec%0d", i), {busy, en, stage, pair, wb_valid, wb_stage, wb_pair},
            {vecs[i].busy, vecs[i].en, 4'd0, vecs[i].pair, vecs[i].wbv, 4'd0, vecs[i].wbp});
      if (i == 1) t0 = cyc - 1;
    end
    wait_done(dcyc);
    check("t1_latency", 64'(dcyc - t0), 64'(XFER_CYC + 2));
    after_done(XFER_CYC + 2);

    // Transform 2: restart attempt at stage 3, five-cycle hold at stage 4 pair 100.
    do_start(t0);
    n = 0;
    while (!(en === 1'b1 && stage == 4'd3) && n < 4000) begin step(); n++; end
    check("reach_stage3", n < 4000, 1);
    start = 1;
    step();
    start = 0;
    check("restart_ignored", {busy, en, stage, pair}, {1'b1, 1'b1, 4'd3, 9'd1});
    n = 0;
    while (!(en === 1'b1 && stage == 4'd4 && pair == 9'd100) && n < 4000) begin step(); n++; end
    check("reach_s4p100", n < 4000, 1);
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_pair", {en, stage, pair}, {1'b0, 4'd4, 9'd100});
    end
    hold = 0;
    step();
    check("hold_resume", {en, stage, pair}, {1'b1, 4'd4, 9'd101});
    wait_done(dcyc);
    check("t2_latency", 64'(dcyc - t0), 64'(XFER_CYC + 5));
    after_done(XFER_CYC + 5);

    // Transform 3: random holds, abandoned by reset at stage 6 pair 300.
    do_start(t0);
    n = 0;
    while (!(en === 1'b1 && stage == 4'd6 && pair == 9'd300) && n < 8000) begin
      hold = ($urandom_range(0, 15) == 0);
      step();
      n++;
    end
    hold = 0;
    check("reach_s6p300", n < 8000, 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_reset", {busy, done, en, stage, pair, wb_valid, wb_stage, wb_pair}, 0);
    repeat (2) step();
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0) n++;
    end
    check("no_done_after_reset", n, 0);

    // Transform 4: random holds and stray start pulses while busy.
    rand_hold = 1; rand_start = 1;
    h0 = m_held;
    do_start(t0);
    wait_done(dcyc);
    rand_hold = 0; rand_start = 0;
    check("t4_latency", 64'(dcyc - t0), 64'(XFER_CYC + (m_held - h0)));
    after_done(XFER_CYC + (m_held - h0));

    // Transform 5: clean run.
    do_start(t0);
    wait_done(dcyc);
    check("t5_latency", 64'(dcyc - t0), 64'(XFER_CYC));
    after_done(XFER_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the in-place radix-2 FFT core. It sits directly upstream of the address generator and drives the generator's enable, stage and pair inputs, walking pair 0..511 of stage 0..9 once per transform. It also delays a write-back tag `{valid, stage, pair}` by the butterfly datapath latency, so the write side is presented with the stage/pair whose results are arriving. Between stages it inserts a drain gap so that the next stage never reads a bank location before the previous stage has written it.

## Interface
Parameters:
- `LOG2N`, default 10: log2 of transform size. There are LOG2N stages and 2^(LOG2N-1) pairs per stage.
- `PIPE_LAT`, default 3, range 1..15: cycles from a read issue (`o_en`) to the butterfly result being ready to write.

Ports:
- `i_clk` input 1: single clock. All state updates on the rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_start` input 1: start one transform. Sampled only in IDLE.
- `i_hold` input 1: pause issue. Pair/stage counters freeze and `o_en`=0.
- `o_busy` output 1: high in RUN, DRAIN and DONE.
- `o_done` output 1: one-cycle pulse when the last write-back has been presented.
- `o_en` output 1: read-issue enable to the address generator.
- `o_stage` output 4: current issue stage.
- `o_pair` output 9: current issue pair.
- `o_wb_valid` output 1: write-back tag valid. Gates the memory write enables.
- `o_wb_stage` output 4: stage of the result being written.
- `o_wb_pair` output 9: pair of the result being written.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on `i_start`=1, go to RUN with stage=0 and pair=0.
- RUN: when `i_hold`=0, `o_en`=1 and pair increments each cycle.
  - At pair=511 with no hold, the issue completes and the FSM goes to DRAIN. Pair wraps to 0.
- DRAIN: `o_en`=0 for exactly PIPE_LAT cycles, counted by a drain counter.
  - At the end of the drain, if stage<LOG2N-1: stage increments and the FSM returns to RUN.
  - Otherwise the FSM goes to DONE.
- DONE: `o_done`=1 for one cycle, then the FSM returns to IDLE. Stage and pair clear to 0.
- `i_hold` during RUN: freezes pair/stage and forces `o_en`=0 for the current cycle.
  - The write-back delay line keeps shifting, so bubbles appear as `o_wb_valid`=0.
- `i_hold` is ignored in DRAIN and DONE.
- `i_start` outside IDLE is ignored. There is no queueing.
- `o_en`, `o_stage` and `o_pair` are registered outputs.
- Write-back tag: a PIPE_LAT-deep shift register of `{o_en, o_stage, o_pair}`. Its tail drives `o_wb_*`.
- Counter arithmetic: pair counter is 9 bits (LOG2N-1), modulo 512. Stage counter is 4 bits (clog2(LOG2N)) and saturates; it never exceeds LOG2N-1.
- Reset mid-transform: all state is abandoned immediately and the FSM is in IDLE. No completion pulse is produced.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_en`=0, `o_stage`=0, `o_pair`=0, `o_wb_valid`=0, `o_wb_stage`=0, `o_wb_pair`=0. All delay-line entries are 0, and `o_cycles`=0 when enabled.
- `i_start` sampled high at edge k: `o_en`=1 with stage 0, pair 0 during cycle k+1.
- `o_wb_*` equals the `o_en`/`o_stage`/`o_pair` values from exactly PIPE_LAT cycles earlier.
- Unheld transform: each stage occupies 512 RUN cycles plus PIPE_LAT DRAIN cycles.
- The last write-back (stage 9, pair 511) is valid in the final DRAIN cycle.
- `o_done` pulses in the following cycle.
- `i_start` to `o_done` is 10·(512+PIPE_LAT)+1 cycles (5151 at defaults) plus any held cycles.

## Configuration
- Macro `FFT_SEQ_CYCLE_COUNT_EN` defined:
  - Adds output port `o_cycles` (16 bits).
  - The counter clears on an accepted `i_start` and increments every busy cycle.
  - It freezes when DONE is entered and holds its value until the next start.
  - It saturates at 0xFFFF.
- Undefined: the port and counter are absent. No other behaviour changes.

## Structure
- Shared package `fft_pkg` holds:
  - `LOG2N`, `N_PAIRS`, `STAGE_W` and `PAIR_W` constants.
  - The `fft_seq_state_t` enum {IDLE, RUN, DRAIN, DONE}.
  - The write-back tag struct `fft_wb_tag_t` {valid, stage, pair}.
- One sub-module, `fft_tag_delay`: a parameterised-depth shift register of `fft_wb_tag_t` with async active-low reset.
- The FSM and counters stay in `fft_sequencer`.

## Test plan
- Reset, then a start pulse.
  - `o_en` rises one cycle later with stage=0, pair=0.
  - `o_wb_valid` rises 3 cycles after `o_en`.
  - `o_done` arrives 5151 cycles after start.
- Stage-1 to stage-2 boundary:
  - After stage 1, pair 511, `o_en`=0 for exactly 3 cycles.
  - Next issue is stage=2, pair=0.
  - The last stage-1 write-back precedes the first stage-2 read.
- `i_hold`=1 for 5 cycles at stage 4, pair 100:
  - Pair stays at 100 during the hold.
  - Exactly 5 bubbles appear on `o_wb_valid` 3 cycles later.
  - `o_done` is delayed by 5 cycles.
- `i_start` re-asserted at stage 3:
  - No restart occurs.
  - A second start after `o_done` begins a clean transform.
- `i_rst_n` asserted at stage 6, pair 300:
  - All outputs are 0 immediately.
  - No `o_done` is produced.
  - The next start runs a full transform.
- With `FFT_SEQ_CYCLE_COUNT_EN` defined:
  - `o_cycles`=5151 after `o_done`.
  - With PIPE_LAT=1, `o_cycles`=5131.
